mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter_pkg.sv | 39 +++
 rtl/mux_rr_arbiter_mux_4_1.sv | 22 ++
 rtl/mux_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
// Shared definitions for the round-robin muxing arbiter:
//   - state_t          : arbiter state encoding (IDLE = 0, BUSY = 1)
//   - SRC_A..SRC_D     : source indices 0..3
//   - DEFAULT_MAX_HOLD : default cap on consecutive grant cycles
//   - rr_pick()        : round-robin search helper returning {found, index}
package mux_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int SRC_A = 0;
  localparam int SRC_B = 1;
  localparam int SRC_C = 2;
  localparam int SRC_D = 3;
  localparam int NUM_SRC = 4;

  localparam int DEFAULT_MAX_HOLD = 8;

  // Finds the first set bit of cand, searching upward mod 4 from ptr.
  // The loop runs from the farthest offset down to offset 0, so the
  // closest hit to ptr is the last one written and therefore wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                         input logic [1:0] ptr);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (cand[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux_4_1.sv
// mux_4_1
// One-bit 4:1 multiplexer used as the datapath slice of the arbiter.
// Ports:
//   d   in  4  data inputs, d[i] selected when sel == i
//   sel in  2  binary select {S1,S0}
//   y   out 1  selected data bit
module mux_4_1 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);

  always_comb begin
    case (sel)
      2'd0:    y = d[0];
      2'd1:    y = d[1];
      2'd2:    y = d[2];
      default: y = d[3];
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Four-source round-robin arbiter that steers the granted source's data
// through a bank of 4:1 muxes. A requester keeps its grant for at most
// MAX_HOLD consecutive cycles while somebody else is waiting; if nobody
// else wants the resource, the holder keeps it indefinitely.
// MAX_HOLD must be at least 1.
// Ports:
//   clk       in  1    rising-edge clock
//   rst_n     in  1    asynchronous active-low reset
//   req       in  4    requests, bit 0 = A .. bit 3 = D
//   data_in   in  4*W  source data, slice i = data_in[i*W +: W]
//   gnt       out 4    registered one-hot grant, zero when idle
//   sel       out 2    registered binary index of the granted source
//   data_out  out W    registered data of the granted source
//   out_valid out 1    registered, data_out valid this cycle
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] data_in,
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic [W-1:0]   data_out,
  output logic           out_valid
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

  state_t        state_q, state_d;
  logic [3:0]    gnt_d;
  logic [1:0]    sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    pick_all;
  logic [2:0]    pick_oth;
  logic          take;
  logic [1:0]    take_idx;
  logic [W-1:0]  mux_y;

  // pick_oth masks out the current holder so a forced hand-off can never
  // land back on it.
  assign pick_all = rr_pick(req, ptr_q);
  assign pick_oth = rr_pick(req & ~gnt, ptr_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt;
    sel_d    = sel;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    take     = 1'b0;
    take_idx = sel;
    case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          take     = 1'b1;
          take_idx = pick_all[1:0];
        end
      end
      BUSY: begin
        if (!req[sel]) begin
          // Holder let go: hand over in the same edge, or fall idle.
          if (pick_all[2]) begin
            take     = 1'b1;
            take_idx = pick_all[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (hold_q < MAX_HOLD_C) begin
          hold_d = hold_q + HW'(1);
        end else if (pick_oth[2]) begin
          take     = 1'b1;
          take_idx = pick_oth[1:0];
        end
        // Otherwise: at the cap with nobody waiting, keep and saturate.
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    // gnt is rewritten as a whole, so a hand-off moves directly from one
    // one-hot value to the next and is never two-hot.
    if (take) begin
      state_d = BUSY;
      gnt_d   = 4'b0001 << take_idx;
      sel_d   = take_idx;
      ptr_d   = take_idx + 2'd1;
      hold_d  = HW'(1);
    end
  end

  // One 4:1 mux per data bit, all steered by the registered select.
  for (genvar b = 0; b < W; b++) begin : g_mux
    mux_4_1 u_mux (
      .d   ({data_in[3*W+b], data_in[2*W+b], data_in[W+b], data_in[b]}),
      .sel (sel),
      .y   (mux_y[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      ptr_q     <= 2'(SRC_A);
      hold_q    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      sel       <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      data_out  <= (|gnt) ? mux_y : '0;
      out_valid <= |gnt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
// Self-checking bench for mux_rr_arbiter: directed scenarios with literal
// expectations, then randomized requests checked every cycle against a
// behavioural model of the round-robin / max-hold rules.
module tb_mux_rr_arbiter;

  localparam int W        = 4;
  localparam int MAX_HOLD = 8;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] data_in;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic [W-1:0]   data_out;
  logic           out_valid;

  int pass_count  = 0;
  int check_count = 0;
  bit check_en    = 1'b0;

  mux_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .sel       (sel),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: granted index (-1 when idle), round-robin pointer,
  // consecutive-hold count and the outputs expected after each edge.
  int           m_g    = -1;
  int           m_ptr  = 0;
  int           m_hold = 0;
  int           m_sel  = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;

  function automatic int rrFind(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_g = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
      m_valid = 1'b0; m_data = '0;
    end else begin
      m_valid = (m_g >= 0);
      m_data  = (m_g >= 0) ? data_in[m_g*W +: W] : '0;
      w = -1;
      if (m_g < 0) begin
        w = rrFind(req, m_ptr, -1);
      end else if (!req[m_g]) begin
        w = rrFind(req, m_ptr, -1);
        if (w < 0) begin
          m_g = -1;
          m_hold = 0;
        end
      end else if (m_hold < MAX_HOLD) begin
        m_hold = m_hold + 1;
      end else begin
        w = rrFind(req, m_ptr, m_g);
      end
      if (w >= 0) begin
        m_g = w; m_ptr = (w + 1) % 4; m_hold = 1; m_sel = w;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [4*W-1:0] d);
    req     = r;
    data_in = d;
  endtask

  // Reset asserted away from the clock edges, released on a falling edge.
  task automatic resetPulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Every-cycle comparison against the model plus structural properties.
  always @(negedge clk) begin
    logic [3:0] eg;
    if (rst_n && check_en) begin
      eg = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
      checkOutput("cmp_gnt", gnt, eg);
      checkOutput("cmp_sel", sel, m_sel);
      checkOutput("cmp_valid", out_valid, m_valid);
      checkOutput("cmp_data", data_out, m_data);
      checkOutput("onehot0", $onehot0(gnt), 1);
      checkOutput("sel_enc", (gnt == 4'b0) || (gnt == (4'b0001 << sel)), 1);
    end
  end

  logic [3:0] seq29 [5];
  logic [3:0] r;

  initial begin
    seq29 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b1;
    applyStimulus(4'b0000, '0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    checkOutput("reset_gnt", gnt, 4'b0000);
    checkOutput("reset_sel", sel, 2'd0);
    checkOutput("reset_valid", out_valid, 1'b0);
    checkOutput("reset_data", data_out, 4'h0);

    // Single requester A, three cycles.
    applyStimulus(4'b0001, 16'h5E7A);
    @(negedge clk);
    checkOutput("a_gnt", gnt, 4'b0001);
    checkOutput("a_sel", sel, 2'd0);
    checkOutput("a_valid_lag", out_valid, 1'b0);
    @(negedge clk);
    checkOutput("a_valid", out_valid, 1'b1);
    checkOutput("a_data", data_out, 4'hA);
    @(negedge clk);
    applyStimulus(4'b0000, 16'h5E7A);

    // Everyone requests, each drops after one grant cycle.
    resetPulse();
    applyStimulus(4'b1111, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rr_gnt", gnt, seq29[i]);
      checkOutput("rr_sel", sel, i % 4);
      if (i > 0) checkOutput("rr_nobubble", out_valid, 1'b1);
      applyStimulus(4'b1111 & ~seq29[i], 16'h1234);
    end

    // A and B held: forced hand-off every MAX_HOLD cycles.
    resetPulse();
    applyStimulus(4'b0011, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("hold_gnt", gnt, (i >= 8 && i < 16) ? 4'b0010 : 4'b0001);
    end

    // C alone for 20 cycles, then B appears: the saturated count forces
    // an immediate hand-off; then everyone drops.
    resetPulse();
    applyStimulus(4'b0100, 16'h0C00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("sat_gnt", gnt, 4'b0100);
    end
    applyStimulus(4'b0110, 16'h0C00);
    @(negedge clk);
    checkOutput("sat_handoff", gnt, 4'b0010);
    applyStimulus(4'b0000, 16'h0C00);
    @(negedge clk);
    checkOutput("idle_gnt", gnt, 4'b0000);
    checkOutput("idle_valid_lag", out_valid, 1'b1);
    @(negedge clk);
    checkOutput("idle_valid", out_valid, 1'b0);

    // Reset in the middle of a grant to D.
    resetPulse();
    applyStimulus(4'b1000, 16'h9000);
    @(negedge clk);
    checkOutput("d_gnt", gnt, 4'b1000);
    checkOutput("d_sel", sel, 2'd3);
    @(negedge clk);
    checkOutput("d_data", data_out, 4'h9);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_gnt", gnt, 4'b0000);
    checkOutput("async_sel", sel, 2'd0);
    checkOutput("async_valid", out_valid, 1'b0);
    checkOutput("async_data", data_out, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1001, 16'h9001);
    @(negedge clk);
    checkOutput("post_reset_a", gnt, 4'b0001);

    // Randomized traffic with sticky request bits and occasional resets.
    r = 4'b0000;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        resetPulse();
      end else begin
        @(negedge clk);
      end
      if ($urandom_range(0, 39) == 0) r = 4'b0000;
      else r = r ^ (4'($urandom) & 4'($urandom));
      applyStimulus(r, 16'($urandom));
    end
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
